// File: rtl/data_mem_uart_dump.sv
// Byte-lane RV32 data memory (big-endian within a word) with a back-door init
// port and a UART 8N1 engine that streams a byte range of the memory on tx.
module data_mem_uart_dump #(
    parameter int ADDR_W   = 5,
    parameter int CLK_FREQ = 50000000,
    parameter int UART_BPS = 115200
) (
    input  logic              sys_clk,
    input  logic              sys_arst,
    input  logic [7:0]        ctrl,
    input  logic [31:0]       addr,
    input  logic [31:0]       data_in,
    output logic [31:0]       data_out,
    output logic              misalign,
    input  logic              init_en,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [31:0]       init_data,
    input  logic              dump_start,
    input  logic [ADDR_W-1:0] dump_base,
    input  logic [ADDR_W:0]   dump_len,
    output logic              dump_busy,
    output logic              dump_done,
    output logic              tx
);

    localparam int DEPTH   = 2**ADDR_W;
    localparam int BIT_CYC = CLK_FREQ / UART_BPS;
    localparam int CYC_W   = (BIT_CYC > 2) ? $clog2(BIT_CYC) : 1;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, FETCH, SEND, FIN} state_t;

    logic [7:0] mem [DEPTH];

    logic [ADDR_W-1:0] a;
    logic              ld_en, st_en, ld_mis, st_mis, st_we;
    logic [2:0]        ld_f, st_f;
    logic [31:0]       rd_word;
    logic [31:0]       ld_data_p1;
    logic              misalign_p1;
    logic              unused_bits;

    function automatic logic is_misaligned(input logic [2:0] f, input logic [1:0] off);
        case (f)
            F_H, F_HU: is_misaligned = off[0];
            F_W:       is_misaligned = (off != 2'b00);
            default:   is_misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic store_supported(input logic [2:0] f);
        store_supported = (f == F_B) || (f == F_H) || (f == F_W);
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f, input logic [31:0] w,
                                                input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        h = off[1] ? w[15:0] : w[31:16];
        case (f)
            F_B:     load_extend = 32'(signed'(b));
            F_H:     load_extend = 32'(signed'(h));
            F_W:     load_extend = w;
            F_BU:    load_extend = {24'd0, b};
            F_HU:    load_extend = {16'd0, h};
            default: load_extend = 32'd0;
        endcase
    endfunction

    assign unused_bits = ^{addr[31:ADDR_W], init_addr[1:0]};

    assign a      = addr[ADDR_W-1:0];
    assign ld_en  = ctrl[7];
    assign ld_f   = ctrl[6:4];
    assign st_en  = ctrl[3] & ~ctrl[7];
    assign st_f   = ctrl[2:0];
    assign ld_mis = is_misaligned(ld_f, a[1:0]);
    assign st_mis = is_misaligned(st_f, a[1:0]);
    assign st_we  = st_en & ~init_en & ~st_mis & store_supported(st_f);

    assign rd_word = {mem[{a[ADDR_W-1:2], 2'd0}], mem[{a[ADDR_W-1:2], 2'd1}],
                      mem[{a[ADDR_W-1:2], 2'd2}], mem[{a[ADDR_W-1:2], 2'd3}]};

    // Write port: back-door init has priority over core stores
    always_ff @(posedge sys_clk or posedge sys_arst) begin
        if (sys_arst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'd0;
        end else if (init_en) begin
            mem[{init_addr[ADDR_W-1:2], 2'd0}] <= init_data[31:24];
            mem[{init_addr[ADDR_W-1:2], 2'd1}] <= init_data[23:16];
            mem[{init_addr[ADDR_W-1:2], 2'd2}] <= init_data[15:8];
            mem[{init_addr[ADDR_W-1:2], 2'd3}] <= init_data[7:0];
        end else if (st_we) begin
            case (st_f)
                F_B: mem[a] <= data_in[7:0];
                F_H: begin
                    mem[{a[ADDR_W-1:1], 1'b0}] <= data_in[15:8];
                    mem[{a[ADDR_W-1:1], 1'b1}] <= data_in[7:0];
                end
                default: begin
                    mem[{a[ADDR_W-1:2], 2'd0}] <= data_in[31:24];
                    mem[{a[ADDR_W-1:2], 2'd1}] <= data_in[23:16];
                    mem[{a[ADDR_W-1:2], 2'd2}] <= data_in[15:8];
                    mem[{a[ADDR_W-1:2], 2'd3}] <= data_in[7:0];
                end
            endcase
        end
    end

    // Load stage p1: registered result, zero when no valid load preceded
    always_ff @(posedge sys_clk or posedge sys_arst) begin
        if (sys_arst) begin
            ld_data_p1  <= 32'd0;
            misalign_p1 <= 1'b0;
        end else begin
            ld_data_p1  <= (ld_en && !ld_mis) ? load_extend(ld_f, rd_word, a[1:0]) : 32'd0;
            misalign_p1 <= ld_en ? ld_mis : (st_en & st_mis);
        end
    end

    assign data_out = ld_data_p1;
    assign misalign = misalign_p1;

    state_t            state, state_n;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   rem;
    logic [7:0]        shreg;
    logic [CYC_W-1:0]  cyc;
    logic [3:0]        bit_idx;
    logic              bit_end, frame_end;

    assign bit_end   = (cyc == CYC_W'(BIT_CYC - 1));
    assign frame_end = bit_end && (bit_idx == 4'd9);

    always_ff @(posedge sys_clk or posedge sys_arst) begin
        if (sys_arst) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (dump_start) state_n = (dump_len == '0) ? FIN : FETCH;
            FETCH:   state_n = SEND;
            SEND:    if (frame_end) state_n = (rem == (ADDR_W+1)'(1)) ? FIN : FETCH;
            default: state_n = IDLE;
        endcase
    end

    // Dump datapath: pointer, remaining count, shift register and bit timing
    always_ff @(posedge sys_clk or posedge sys_arst) begin
        if (sys_arst) begin
            ptr     <= '0;
            rem     <= '0;
            shreg   <= 8'd0;
            cyc     <= '0;
            bit_idx <= 4'd0;
        end else begin
            case (state)
                IDLE: if (dump_start) begin
                    ptr <= dump_base;
                    rem <= dump_len;
                end
                FETCH: begin
                    shreg   <= mem[ptr];
                    cyc     <= '0;
                    bit_idx <= 4'd0;
                end
                SEND: begin
                    if (bit_end) begin
                        cyc <= '0;
                        if (bit_idx == 4'd9) begin
                            bit_idx <= 4'd0;
                            ptr     <= ptr + 1'b1;
                            rem     <= rem - 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        tx = 1'b1;
        if (state == SEND) begin
            case (bit_idx)
                4'd0:    tx = 1'b0;
                4'd9:    tx = 1'b1;
                default: tx = shreg[3'(bit_idx - 4'd1)];
            endcase
        end
    end

    assign dump_busy = (state == FETCH) || (state == SEND);
    assign dump_done = (state == FIN);

endmodule

// File: tb/tb_data_mem_uart_dump.sv
// Directed bench for data_mem_uart_dump: loads/stores, priority rules,
// UART dump with address wrap, zero-length dump and mid-frame reset.
module tb_data_mem_uart_dump;

    localparam int AW = 5;

    logic          sys_clk = 1'b0;
    logic          sys_arst;
    logic [7:0]    ctrl;
    logic [31:0]   addr, data_in, data_out, init_data;
    logic          misalign, init_en, dump_start, dump_busy, dump_done, tx;
    logic [AW-1:0] init_addr, dump_base;
    logic [AW:0]   dump_len;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int cnt0;
    logic [7:0] rx;

    data_mem_uart_dump #(.ADDR_W(AW), .CLK_FREQ(1000), .UART_BPS(100)) dut (
        .sys_clk(sys_clk), .sys_arst(sys_arst), .ctrl(ctrl), .addr(addr),
        .data_in(data_in), .data_out(data_out), .misalign(misalign),
        .init_en(init_en), .init_addr(init_addr), .init_data(init_data),
        .dump_start(dump_start), .dump_base(dump_base), .dump_len(dump_len),
        .dump_busy(dump_busy), .dump_done(dump_done), .tx(tx)
    );

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) if (dump_done) done_cnt <= done_cnt + 1;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [2:0] f, input logic [31:0] a);
        ctrl = {1'b1, f, 4'b0000};
        addr = a;
        tick();
        ctrl = 8'h00;
    endtask

    task automatic store(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        ctrl    = {4'b0000, 1'b1, f};
        addr    = a;
        data_in = d;
        tick();
        ctrl = 8'h00;
    endtask

    task automatic init_w(input logic [AW-1:0] a, input logic [31:0] d);
        init_en   = 1'b1;
        init_addr = a;
        init_data = d;
        tick();
        init_en = 1'b0;
    endtask

    // Returns at the middle of the stop bit
    task automatic recv_byte(input string tag, output logic [7:0] b);
        int n;
        b = 8'h00;
        n = 0;
        while (tx !== 1'b0 && n < 300) begin
            tick();
            n++;
        end
        if (tx !== 1'b0) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        repeat (5) tick();
        check({tag, "_start"}, {31'd0, tx}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (10) tick();
            b[i] = tx;
        end
        repeat (10) tick();
        check({tag, "_stop"}, {31'd0, tx}, 32'd1);
    endtask

    initial begin
        sys_arst = 1'b1; ctrl = 8'h00; addr = '0; data_in = '0;
        init_en = 1'b0; init_addr = '0; init_data = '0;
        dump_start = 1'b0; dump_base = '0; dump_len = '0;
        tick(); tick();
        check("rst_data_out", data_out, 32'd0);
        check("rst_misalign", {31'd0, misalign}, 32'd0);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_busy", {31'd0, dump_busy}, 32'd0);
        check("rst_done", {31'd0, dump_done}, 32'd0);
        sys_arst = 1'b0;
        tick();

        init_w(5'd0, 32'h8190A2B3);
        load(3'b000, 32'd1);
        check("lb_1", data_out, 32'hFFFFFF90);
        check("lb_1_mis", {31'd0, misalign}, 32'd0);
        tick();
        check("lb_1_next", data_out, 32'd0);
        load(3'b100, 32'd3);
        check("lbu_3", data_out, 32'h000000B3);
        load(3'b101, 32'd2);
        check("lhu_2", data_out, 32'h0000A2B3);
        load(3'b001, 32'd0);
        check("lh_0", data_out, 32'hFFFF8190);

        store(3'b000, 32'd6, 32'h0000005A);
        load(3'b010, 32'd4);
        check("sb6_lw4", data_out, 32'h00005A00);
        store(3'b001, 32'hFFFF_FF08, 32'h00001234);
        load(3'b010, 32'd8);
        check("sh8_lw8", data_out, 32'h12340000);

        store(3'b010, 32'd5, 32'hFFFFFFFF);
        check("sw5_mis", {31'd0, misalign}, 32'd1);
        load(3'b010, 32'd4);
        check("sw5_nowrite", data_out, 32'h00005A00);
        check("lw4_mis", {31'd0, misalign}, 32'd0);
        load(3'b001, 32'd3);
        check("lh3_data", data_out, 32'd0);
        check("lh3_mis", {31'd0, misalign}, 32'd1);

        ctrl = 8'hAA; addr = 32'd0; data_in = 32'hDEADBEEF;
        tick();
        ctrl = 8'h00;
        check("ldst_old", data_out, 32'h8190A2B3);
        load(3'b010, 32'd0);
        check("ldst_unchanged", data_out, 32'h8190A2B3);
        init_en = 1'b1; init_addr = 5'd12; init_data = 32'hCAFEF00D;
        ctrl = 8'h0A; addr = 32'd12; data_in = 32'h11111111;
        tick();
        init_en = 1'b0; ctrl = 8'h00;
        load(3'b010, 32'd12);
        check("init_wins", data_out, 32'hCAFEF00D);

        init_w(5'd28, 32'h00004142);
        store(3'b000, 32'd0, 32'h00000043);
        cnt0 = done_cnt;
        dump_start = 1'b1; dump_base = 5'd30; dump_len = 6'd3;
        tick();
        dump_start = 1'b0;
        check("dump_busy_rise", {31'd0, dump_busy}, 32'd1);
        recv_byte("frame0", rx);
        check("frame0_byte", {24'd0, rx}, 32'h41);
        dump_start = 1'b1; dump_base = 5'd0; dump_len = 6'd1;
        tick();
        dump_start = 1'b0;
        recv_byte("frame1", rx);
        check("frame1_byte", {24'd0, rx}, 32'h42);
        recv_byte("frame2", rx);
        check("frame2_byte", {24'd0, rx}, 32'h43);
        repeat (4) tick();
        check("pre_done", {31'd0, dump_done}, 32'd0);
        check("pre_done_busy", {31'd0, dump_busy}, 32'd1);
        tick();
        check("done_pulse", {31'd0, dump_done}, 32'd1);
        check("done_busy", {31'd0, dump_busy}, 32'd0);
        tick();
        check("done_end", {31'd0, dump_done}, 32'd0);
        repeat (120) tick();
        check("idle_tx", {31'd0, tx}, 32'd1);
        check("done_count", done_cnt - cnt0, 32'd1);

        dump_start = 1'b1; dump_base = 5'd5; dump_len = 6'd0;
        tick();
        dump_start = 1'b0;
        check("len0_done", {31'd0, dump_done}, 32'd1);
        check("len0_busy", {31'd0, dump_busy}, 32'd0);
        check("len0_tx", {31'd0, tx}, 32'd1);
        tick();
        check("len0_done_end", {31'd0, dump_done}, 32'd0);
        check("len0_tx_end", {31'd0, tx}, 32'd1);

        dump_start = 1'b1; dump_base = 5'd0; dump_len = 6'd2;
        tick();
        dump_start = 1'b0;
        begin
            int n = 0;
            while (tx !== 1'b0 && n < 50) begin
                tick();
                n++;
            end
        end
        repeat (35) tick();
        check("mid_bit2", {31'd0, tx}, 32'd0);
        cnt0 = done_cnt;
        sys_arst = 1'b1;
        #1;
        check("arst_tx", {31'd0, tx}, 32'd1);
        check("arst_busy", {31'd0, dump_busy}, 32'd0);
        check("arst_done", {31'd0, dump_done}, 32'd0);
        tick(); tick();
        sys_arst = 1'b0;
        tick();
        load(3'b010, 32'd0);
        check("arst_mem0", data_out, 32'd0);
        load(3'b010, 32'd28);
        check("arst_mem28", data_out, 32'd0);
        repeat (20) tick();
        check("arst_no_done", done_cnt - cnt0, 32'd0);
        check("arst_tx_idle", {31'd0, tx}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
